// File: rtl/odd_parity_frame_rx_pkg.sv
// Shared definitions for the odd-parity serial frame receiver:
// FSM state encoding and line-level framing constants.
package odd_parity_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/odd_parity_frame_rx.sv
// Serial frame receiver: start / DATA_W data bits (LSB first) / odd parity / stop,
// with per-frame parity and framing flags and a saturating error counter.
module odd_parity_frame_rx
  import odd_parity_frame_rx_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_bit,
  input  logic              bit_en,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int              BCW      = $clog2(DATA_W);
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              par_acc_q, par_acc_d;
  logic              par_ok_q, par_ok_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      par_acc_q <= 1'b0;
      par_ok_q  <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      par_acc_q <= par_acc_d;
      par_ok_q  <= par_ok_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Result flags are single-cycle pulses; everything else freezes between strobes.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    par_acc_d = par_acc_q;
    par_ok_d  = par_ok_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (rx_bit == START_BIT) begin
            state_d   = DATA;
            shreg_d   = '0;
            bit_cnt_d = '0;
            par_acc_d = 1'b0;
          end
        end
        DATA: begin
          shreg_d   = {rx_bit, shreg_q[DATA_W-1:1]};
          par_acc_d = par_acc_q ^ rx_bit;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_ok_d = par_acc_q ^ rx_bit;
          state_d  = STOP;
        end
        STOP: begin
          data_d  = shreg_q;
          valid_d = 1'b1;
          perr_d  = ~par_ok_q;
          ferr_d  = (rx_bit != STOP_BIT);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counts on the pulse cycle itself so a coincident clear wins outright.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (valid_q && (perr_q || ferr_q) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);
  assign err_cnt    = cnt_q;

endmodule
